// File: rtl/rip_common_pkg.sv
// Shared types and constants for the RIP fetch stage.
package rip_common;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RIP_NOP              = 32'h0000_0013;
  localparam logic [31:0] RIP_RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/rip_fetch_skid.sv
// One-entry instruction/PC holding buffer used while decode is stalled.
module rip_fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  // Flush wins over load so a redirect never leaves a stale word behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= 32'h0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/rip_fetch.sv
// RV32I instruction-fetch stage: PC ownership, single-outstanding imem handshake,
// stall holding via a one-entry skid buffer, and redirect with in-flight drop.
module rip_fetch
  import rip_common::*;
#(
  parameter logic [31:0] RESET_PC = RIP_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_stall_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        de_ready_o,
  output logic [31:0] inst_code_o,
  output logic [31:0] if_pc_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         drop_q, drop_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  if_pc_q, if_pc_d;

  logic         req_active, accept;
  logic         skid_load, skid_unload, skid_flush;
  logic         skid_valid;
  logic [31:0]  skid_inst, skid_pc;

  assign req_active = (state_q == REQ);
  assign accept     = req_active && imem_ack_i && !drop_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    drop_addr_d = drop_addr_q;
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    if_pc_d     = if_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (ex_redirect_i) begin
      out_valid_d = 1'b0;
      skid_flush  = 1'b1;
      pc_d        = word_align(ex_redirect_pc_i);
      state_d     = REQ;
      // An unacked request keeps its address on the bus until memory answers.
      if (req_active && !imem_ack_i) begin
        drop_d = 1'b1;
        if (!drop_q) drop_addr_d = pc_q;
      end else begin
        drop_d = 1'b0;
      end
    end else begin
      if (req_active && imem_ack_i && drop_q) drop_d = 1'b0;
      if (!ex_stall_i) out_valid_d = 1'b0;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (accept) begin
            pc_d = pc_q + 32'd4;
            if (!out_valid_q || !ex_stall_i) begin
              out_valid_d = 1'b1;
              inst_d      = imem_rdata_i;
              if_pc_d     = pc_q;
            end else begin
              skid_load = 1'b1;
              state_d   = FULL;
            end
          end
        end
        FULL: begin
          if (!ex_stall_i) begin
            out_valid_d = 1'b1;
            inst_d      = skid_inst;
            if_pc_d     = skid_pc;
            skid_unload = 1'b1;
            state_d     = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      drop_addr_q <= RESET_PC;
      out_valid_q <= 1'b0;
      inst_q      <= 32'h0;
      if_pc_q     <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      drop_addr_q <= drop_addr_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      if_pc_q     <= if_pc_d;
    end
  end

  rip_fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .inst_i   (imem_rdata_i),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .inst_o   (skid_inst),
    .pc_o     (skid_pc)
  );

  // skid_valid mirrors state FULL; kept for visibility when debugging.
  logic skid_valid_unused;
  assign skid_valid_unused = skid_valid;

  assign imem_req_o  = req_active;
  assign imem_addr_o = drop_q ? drop_addr_q : pc_q;
  assign de_ready_o  = out_valid_q;
  assign inst_code_o = inst_q;
  assign if_pc_o     = if_pc_q;

endmodule

// File: tb/tb_rip_fetch.sv
// Directed bench for rip_fetch: vector table for streaming/stall/redirect,
// hand sequences for latency drop, stall+redirect, PC wrap and mid-run reset.
module tb_rip_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_stall, ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        imem_req, imem_ack, de_ready;
  logic [31:0] imem_addr, imem_rdata, inst_code, if_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wait_cnt;

  always #5 clk = ~clk;

  // Memory returns the address as data; ack after `lat` wait cycles.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  rip_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_stall_i       (ex_stall),
    .ex_redirect_i    (ex_redirect),
    .ex_redirect_pc_i (ex_redirect_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .de_ready_o       (de_ready),
    .inst_code_o      (inst_code),
    .if_pc_o          (if_pc)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        de;
    logic [31:0] inst;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic eq, input logic [31:0] ea, input logic ed,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp;
    v.req = eq; v.addr = ea; v.de = ed; v.inst = ei; v.ipc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic er, input logic [31:0] ea,
                       input logic ed, input logic [31:0] ei, input logic [31:0] ep);
    n_tests++;
    if (imem_req !== er || imem_addr !== ea || de_ready !== ed ||
        inst_code !== ei || if_pc !== ep) begin
      n_fail++;
      $display("FAIL %s: got req=%0b addr=%h de=%0b inst=%h pc=%h, want req=%0b addr=%h de=%0b inst=%h pc=%h",
               name, imem_req, imem_addr, de_ready, inst_code, if_pc, er, ea, ed, ei, ep);
    end
  endtask

  task automatic step(input string name, input logic er, input logic [31:0] ea,
                      input logic ed, input logic [31:0] ei, input logic [31:0] ep);
    @(posedge clk);
    @(negedge clk);
    check(name, er, ea, ed, ei, ep);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp);
    ex_stall       = s;
    ex_redirect    = r;
    ex_redirect_pc = rp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // observed after posedge k | inputs driven for the following cycle
    tbl[0]  = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h000, 32'h100);
    tbl[1]  = mk(0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 32'h100);
    tbl[2]  = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h104, 32'h104);
    tbl[3]  = mk(1, 0, 32'h0,   0, 32'h10C, 1, 32'h104, 32'h104);
    tbl[4]  = mk(1, 0, 32'h0,   0, 32'h10C, 1, 32'h104, 32'h104);
    tbl[5]  = mk(0, 0, 32'h0,   0, 32'h10C, 1, 32'h104, 32'h104);
    tbl[6]  = mk(0, 0, 32'h0,   1, 32'h10C, 1, 32'h108, 32'h108);
    tbl[7]  = mk(0, 1, 32'h200, 1, 32'h110, 1, 32'h10C, 32'h10C);
    tbl[8]  = mk(0, 0, 32'h0,   1, 32'h200, 0, 32'h10C, 32'h10C);
    tbl[9]  = mk(0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'h200);
    tbl[10] = mk(0, 1, 32'h203, 1, 32'h208, 1, 32'h204, 32'h204);
    tbl[11] = mk(0, 0, 32'h0,   1, 32'h200, 0, 32'h204, 32'h204);
    tbl[12] = mk(0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'h200);
    tbl[13] = mk(0, 1, 32'h110, 1, 32'h208, 1, 32'h204, 32'h204);

    rst_n = 1'b0;
    drive(0, 0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i + 1), tbl[i].req, tbl[i].addr, tbl[i].de,
            tbl[i].inst, tbl[i].ipc);
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
    end

    // Redirect while a slow request to 0x110 is pending: it is dropped.
    step("drop_start", 1, 32'h110, 0, 32'h204, 32'h204);
    lat = 2;
    drive(0, 1, 32'h300);
    step("drop_hold1", 1, 32'h110, 0, 32'h204, 32'h204);
    drive(0, 0, 32'h0);
    step("drop_hold2", 1, 32'h110, 0, 32'h204, 32'h204);
    step("drop_new_req", 1, 32'h300, 0, 32'h204, 32'h204);
    step("drop_wait1", 1, 32'h300, 0, 32'h204, 32'h204);
    step("drop_wait2", 1, 32'h300, 0, 32'h204, 32'h204);
    step("drop_deliver", 1, 32'h304, 1, 32'h300, 32'h300);
    lat = 0;

    // Stall + redirect, both with a full skid and with a live ack.
    step("sr_pre", 1, 32'h308, 1, 32'h304, 32'h304);
    drive(1, 0, 32'h0);
    step("sr_full", 0, 32'h30C, 1, 32'h304, 32'h304);
    drive(1, 1, 32'h500);
    step("sr_flush", 1, 32'h500, 0, 32'h304, 32'h304);
    drive(1, 1, 32'h400);
    step("sr_ack_drop", 1, 32'h400, 0, 32'h304, 32'h304);
    drive(0, 0, 32'h0);
    step("sr_resume", 1, 32'h404, 1, 32'h400, 32'h400);
    step("sr_no_skid", 1, 32'h408, 1, 32'h404, 32'h404);

    // Sequential wrap at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC);
    step("wrap_req", 1, 32'hFFFF_FFFC, 0, 32'h404, 32'h404);
    drive(0, 0, 32'h0);
    step("wrap_zero", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step("wrap_next", 1, 32'h4, 1, 32'h0, 32'h0);

    // Reset with a slow request in flight: nothing is carried across.
    lat = 2;
    rst_n = 1'b0;
    step("rst_mid", 0, 32'h100, 0, 32'h0, 32'h100);
    rst_n = 1'b1;
    step("rst_req1", 1, 32'h100, 0, 32'h0, 32'h100);
    step("rst_req2", 1, 32'h100, 0, 32'h0, 32'h100);
    step("rst_req3", 1, 32'h100, 0, 32'h0, 32'h100);
    step("rst_deliver", 1, 32'h104, 1, 32'h100, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
